// File: rtl/rename_table.sv
// rename_table: register alias table plus circular free list with rename, commit and two-port rollback.
// Defining RENAME_FL_CHECK_EN adds a sticky fl_error output for free-list overflow or underflow.
module rename_table #(
  parameter int NUM_AREG = 64,
  parameter int NUM_PREG = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RN_valid,
  input  logic [5:0] RN_A_rs1,
  input  logic [5:0] RN_A_rs2,
  input  logic [5:0] RN_A_rs3,
  input  logic [5:0] RN_A_rd,
  input  logic       RN_rd_en,
  output logic [6:0] RN_P_rs1,
  output logic [6:0] RN_P_rs2,
  output logic [6:0] RN_P_rs3,
  output logic [6:0] RN_P_rd_new,
  output logic [6:0] RN_P_rd_old,
  output logic       RN_ready,
  input  logic       commit_wb_en,
  input  logic [6:0] commit_P_rd_old,
  input  logic       stall,
  input  logic       rollback_en_0,
  input  logic       rollback_en_1,
  input  logic [5:0] rollback_A_rd_0,
  input  logic [5:0] rollback_A_rd_1,
  input  logic [6:0] rollback_P_rd_old_0,
  input  logic [6:0] rollback_P_rd_old_1,
  input  logic [6:0] rollback_P_rd_new_0,
  input  logic [6:0] rollback_P_rd_new_1,
  output logic [7:0] free_count
`ifdef RENAME_FL_CHECK_EN
  ,
  output logic       fl_error
`endif
);
  localparam int FL = NUM_PREG - NUM_AREG;
  logic [6:0] rat [NUM_AREG];
  logic [6:0] fl [FL];
  logic [5:0] head, tail, t1, t2;
  logic [7:0] count;
  logic [1:0] pushes;
  logic alloc, pop, push_c, push_0, push_1;
  assign alloc = RN_rd_en && RN_A_rd != '0;
  assign RN_P_rs1 = rat[RN_A_rs1];
  assign RN_P_rs2 = rat[RN_A_rs2];
  assign RN_P_rs3 = rat[RN_A_rs3];
  assign RN_P_rd_old = rat[RN_A_rd];
  assign RN_P_rd_new = alloc ? fl[head] : '0;
  assign RN_ready = !stall && (count != '0 || !alloc);
  assign free_count = count;
  assign pop = RN_valid && RN_ready && alloc;
  assign push_c = commit_wb_en && commit_P_rd_old != '0;
  assign push_0 = rollback_en_0 && rollback_P_rd_new_0 != '0;
  assign push_1 = rollback_en_1 && rollback_P_rd_new_1 != '0;
  assign pushes = 2'(push_c) + 2'(push_0) + 2'(push_1);
  // pushes pack contiguously from the tail in commit, rollback 0, rollback 1 order
  assign t1 = tail + 6'(push_c);
  assign t2 = t1 + 6'(push_0);
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_AREG; i++) rat[i] <= 7'(i);
      for (int j = 0; j < FL; j++) fl[j] <= 7'(NUM_AREG + j);
      head <= '0;
      tail <= '0;
      count <= 8'(FL);
    end else begin
      if (pop) begin
        rat[RN_A_rd] <= fl[head];
        head <= head + 6'd1;
      end
      // port 1 is the older entry, so its restore is applied last and wins
      if (push_0 && rollback_A_rd_0 != '0) rat[rollback_A_rd_0] <= rollback_P_rd_old_0;
      if (push_1 && rollback_A_rd_1 != '0) rat[rollback_A_rd_1] <= rollback_P_rd_old_1;
      if (push_c) fl[tail] <= commit_P_rd_old;
      if (push_0) fl[t1] <= rollback_P_rd_new_0;
      if (push_1) fl[t2] <= rollback_P_rd_new_1;
      tail <= tail + 6'(pushes);
      count <= count + 8'(pushes) - 8'(pop);
    end
`ifdef RENAME_FL_CHECK_EN
  logic err_set;
  assign err_set = (9'(count) + 9'(pushes) > 9'(FL) + 9'(pop)) || (pop && count == '0);
  always_ff @(posedge clk)
    if (rst) fl_error <= 1'b0;
    else if (err_set) fl_error <= 1'b1;
`endif
endmodule

// File: tb/tb_rename_table.sv
// tb_rename_table: directed and randomized checks of rename_table against a queue-based reference model.
module tb_rename_table;
  logic clk = 0, rst = 1;
  logic RN_valid, RN_rd_en, RN_ready, commit_wb_en, stall, rollback_en_0, rollback_en_1;
  logic [5:0] RN_A_rs1, RN_A_rs2, RN_A_rs3, RN_A_rd, rollback_A_rd_0, rollback_A_rd_1;
  logic [6:0] RN_P_rs1, RN_P_rs2, RN_P_rs3, RN_P_rd_new, RN_P_rd_old, commit_P_rd_old;
  logic [6:0] rollback_P_rd_old_0, rollback_P_rd_old_1, rollback_P_rd_new_0, rollback_P_rd_new_1;
  logic [7:0] free_count;
`ifdef RENAME_FL_CHECK_EN
  logic fl_error;
`endif
  int checks = 0, errors = 0;
  int m_rat [64];
  int m_fl [$];
  bit m_err;

  rename_table dut (
    .clk(clk), .rst(rst), .RN_valid(RN_valid), .RN_A_rs1(RN_A_rs1), .RN_A_rs2(RN_A_rs2),
    .RN_A_rs3(RN_A_rs3), .RN_A_rd(RN_A_rd), .RN_rd_en(RN_rd_en), .RN_P_rs1(RN_P_rs1),
    .RN_P_rs2(RN_P_rs2), .RN_P_rs3(RN_P_rs3), .RN_P_rd_new(RN_P_rd_new), .RN_P_rd_old(RN_P_rd_old),
    .RN_ready(RN_ready), .commit_wb_en(commit_wb_en), .commit_P_rd_old(commit_P_rd_old),
    .stall(stall), .rollback_en_0(rollback_en_0), .rollback_en_1(rollback_en_1),
    .rollback_A_rd_0(rollback_A_rd_0), .rollback_A_rd_1(rollback_A_rd_1),
    .rollback_P_rd_old_0(rollback_P_rd_old_0), .rollback_P_rd_old_1(rollback_P_rd_old_1),
    .rollback_P_rd_new_0(rollback_P_rd_new_0), .rollback_P_rd_new_1(rollback_P_rd_new_1),
    .free_count(free_count)
`ifdef RENAME_FL_CHECK_EN
    , .fl_error(fl_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RN_valid = 0; RN_rd_en = 0; RN_A_rs1 = 0; RN_A_rs2 = 0; RN_A_rs3 = 0; RN_A_rd = 0;
    commit_wb_en = 0; commit_P_rd_old = 0; stall = 0;
    rollback_en_0 = 0; rollback_en_1 = 0; rollback_A_rd_0 = 0; rollback_A_rd_1 = 0;
    rollback_P_rd_old_0 = 0; rollback_P_rd_old_1 = 0; rollback_P_rd_new_0 = 0; rollback_P_rd_new_1 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 64; i++) m_rat[i] = i;
    m_fl.delete();
    for (int j = 0; j < 64; j++) m_fl.push_back(64 + j);
    m_err = 0;
  endtask

  function automatic int pushes_now();
    return int'(commit_wb_en && commit_P_rd_old != 0) + int'(rollback_en_0 && rollback_P_rd_new_0 != 0)
         + int'(rollback_en_1 && rollback_P_rd_new_1 != 0);
  endfunction

  function automatic int pop_now();
    return int'(RN_valid && !stall && RN_rd_en && RN_A_rd != 0 && m_fl.size() > 0);
  endfunction

  // check outputs against the model, then advance model and DUT by one clock
  task automatic tick();
    bit al, rdy;
    #1;
    al = RN_rd_en && RN_A_rd != 0;
    rdy = !stall && (m_fl.size() != 0 || !al);
    check("P_rs1", RN_P_rs1, m_rat[RN_A_rs1]);
    check("P_rs2", RN_P_rs2, m_rat[RN_A_rs2]);
    check("P_rs3", RN_P_rs3, m_rat[RN_A_rs3]);
    check("P_rd_old", RN_P_rd_old, m_rat[RN_A_rd]);
    if (!al) check("P_rd_new_zero", RN_P_rd_new, 0);
    else if (m_fl.size() > 0) check("P_rd_new", RN_P_rd_new, m_fl[0]);
    check("ready", RN_ready, rdy);
    check("free_count", free_count, m_fl.size());
`ifdef RENAME_FL_CHECK_EN
    check("fl_error", fl_error, m_err);
    if (m_fl.size() + pushes_now() - pop_now() > 64) m_err = 1;
`endif
    if (RN_valid && rdy && al) m_rat[RN_A_rd] = m_fl.pop_front();
    if (commit_wb_en && commit_P_rd_old != 0) m_fl.push_back(commit_P_rd_old);
    if (rollback_en_0 && rollback_P_rd_new_0 != 0) begin
      if (rollback_A_rd_0 != 0) m_rat[rollback_A_rd_0] = rollback_P_rd_old_0;
      m_fl.push_back(rollback_P_rd_new_0);
    end
    if (rollback_en_1 && rollback_P_rd_new_1 != 0) begin
      if (rollback_A_rd_1 != 0) m_rat[rollback_A_rd_1] = rollback_P_rd_old_1;
      m_fl.push_back(rollback_P_rd_new_1);
    end
    @(posedge clk); #1;
  endtask

  task automatic rename(input logic [5:0] rd);
    idle();
    RN_valid = 1; RN_rd_en = 1; RN_A_rd = rd;
    tick();
  endtask

  initial begin
    do_reset();
    #1;
    check("reset_free_count", free_count, 64);
    check("reset_ready", RN_ready, 1);
    RN_rd_en = 1; RN_A_rd = 9; RN_A_rs1 = 33;
    #1;
    check("reset_rd_new", RN_P_rd_new, 64);
    check("reset_rat33", RN_P_rs1, 33);
    idle();
    RN_valid = 1; RN_rd_en = 1; RN_A_rd = 5; RN_A_rs1 = 5;
    #1;
    check("x5_rs1", RN_P_rs1, 5);
    check("x5_rd_old", RN_P_rd_old, 5);
    check("x5_rd_new", RN_P_rd_new, 64);
    tick();
    idle();
    RN_A_rs1 = 5;
    #1;
    check("x5_rat_after", RN_P_rs1, 64);
    check("x5_free_count", free_count, 63);
    RN_valid = 1; RN_rd_en = 1; RN_A_rd = 0; RN_A_rs2 = 0;
    #1;
    check("x0_rd_new", RN_P_rd_new, 0);
    tick();
    idle();
    #1;
    check("x0_free_count", free_count, 63);
    check("x0_rat0", RN_P_rs2, 0);

    for (int n = 0; n < 600; n++) begin
      idle();
      RN_valid = 1'($urandom); RN_rd_en = ($urandom % 4) != 0; RN_A_rd = 6'($urandom);
      RN_A_rs1 = 6'($urandom); RN_A_rs2 = 6'($urandom); RN_A_rs3 = 6'($urandom);
      stall = ($urandom % 4) == 0;
      commit_wb_en = ($urandom % 3) == 0; commit_P_rd_old = 7'($urandom);
      if (stall) begin
        rollback_en_0 = 1'($urandom); rollback_A_rd_0 = 6'($urandom);
        rollback_P_rd_old_0 = 7'($urandom); rollback_P_rd_new_0 = 7'($urandom);
        rollback_en_1 = 1'($urandom); rollback_A_rd_1 = ($urandom % 2) ? rollback_A_rd_0 : 6'($urandom);
        rollback_P_rd_old_1 = 7'($urandom); rollback_P_rd_new_1 = 7'($urandom);
      end
      if (m_fl.size() + pushes_now() - pop_now() > 64) begin
        commit_wb_en = 0; rollback_en_0 = 0; rollback_en_1 = 0;
      end
      tick();
    end

    do_reset();
    for (int i = 0; i < 64; i++) rename(6'((i % 63) + 1));
    idle();
    RN_valid = 1; RN_rd_en = 1; RN_A_rd = 4; commit_wb_en = 1; commit_P_rd_old = 7;
    #1;
    check("empty_free_count", free_count, 0);
    check("empty_ready_with_push", RN_ready, 0);
    tick();
    idle();
    RN_rd_en = 1; RN_A_rd = 4;
    #1;
    check("refill_free_count", free_count, 1);
    check("refill_ready", RN_ready, 1);
    check("refill_rd_new", RN_P_rd_new, 7);
    tick();

    do_reset();
    rename(3);
    rename(3);
    idle();
    stall = 1;
    rollback_en_0 = 1; rollback_A_rd_0 = 3; rollback_P_rd_old_0 = 64; rollback_P_rd_new_0 = 65;
    rollback_en_1 = 1; rollback_A_rd_1 = 3; rollback_P_rd_old_1 = 3; rollback_P_rd_new_1 = 64;
    tick();
    idle();
    RN_A_rs1 = 3;
    #1;
    check("rb_rat3", RN_P_rs1, 3);
    check("rb_free_count", free_count, 64);
    for (int i = 0; i < 62; i++) rename(6'((i % 63) + 1));
    idle();
    RN_rd_en = 1; RN_A_rd = 8;
    #1;
    check("rb_order_first", RN_P_rd_new, 65);
    rename(8);
    idle();
    RN_rd_en = 1; RN_A_rd = 9;
    #1;
    check("rb_order_second", RN_P_rd_new, 64);
    rename(9);

    do_reset();
    for (int i = 0; i < 3; i++) rename(6'(i + 1));
    idle();
    stall = 1; commit_wb_en = 1; commit_P_rd_old = 70;
    rollback_en_0 = 1; rollback_A_rd_0 = 2; rollback_P_rd_old_0 = 2; rollback_P_rd_new_0 = 80;
    rollback_en_1 = 1; rollback_A_rd_1 = 1; rollback_P_rd_old_1 = 1; rollback_P_rd_new_1 = 81;
    tick();
    idle();
    #1;
    check("triple_free_count", free_count, 64);
    for (int i = 0; i < 61; i++) rename(6'((i % 63) + 1));
    for (int k = 0; k < 3; k++) begin
      idle();
      RN_rd_en = 1; RN_A_rd = 10;
      #1;
      check("triple_order", RN_P_rd_new, (k == 0) ? 70 : (k == 1) ? 80 : 81);
      rename(10);
    end

`ifdef RENAME_FL_CHECK_EN
    do_reset();
    idle();
    commit_wb_en = 1; commit_P_rd_old = 10;
    tick();
    idle();
    #1;
    check("fl_error_set", fl_error, 1);
    repeat (3) @(posedge clk);
    #1;
    check("fl_error_sticky", fl_error, 1);
    do_reset();
    #1;
    check("fl_error_cleared", fl_error, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
